// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
//   Shared types and constants for the 4-digit 7-segment scan controller.
//   - scan_state_e : scan FSM states (IDLE, GUARD, DRIVE)
//   - AN_OFF       : all anodes dark (active-low enables)
//   - NUM_DIGITS   : number of multiplexed digits
//   - digit_idx_t  : 2-bit digit index, also the downstream mux select
//   - an_decode    : anode pattern for one lit digit, honouring the blank mask
// ---------------------------------------------------------------------------
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  // Only anode idx may go low; it stays high (dark) when its mask bit is set.
  function automatic logic [3:0] an_decode(input digit_idx_t idx,
                                           input logic [3:0] mask);
    logic [3:0] an;
    an      = AN_OFF;
    an[idx] = mask[idx];
    return an;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_slot_timer.sv
// ---------------------------------------------------------------------------
// slot_timer
//   Per-digit slot counter. Counts 0..DIV-1 and wraps, so one slot is exactly
//   DIV cycles. A synchronous clear parks the count at 0.
//
//   Ports
//     i_clk        : clock, rising edge
//     i_rst_n      : synchronous active-low reset
//     i_clear      : synchronous clear; count held at 0 while high
//     o_guard_done : high while count == GUARD-1 (never high when GUARD == 0)
//     o_slot_end   : high while count == DIV-1
// ---------------------------------------------------------------------------
module slot_timer #(
  parameter int DIV   = 50000,
  parameter int GUARD = 500
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_guard_done,
  output logic o_slot_end
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
  // With no guard interval the compare value is unused; 0 keeps it in range.
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam bit            HAS_GUARD  = (GUARD > 0);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count == SLOT_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_slot_end   = (r_count == SLOT_LAST);
  assign o_guard_done = HAS_GUARD && (r_count == GUARD_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display. Drives the 4:1 pattern mux select and the active-low anodes in
//   lockstep. Each digit slot starts with GUARD dark cycles so the mux output
//   settles before the anode turns on; the remaining DIV-GUARD cycles light
//   the digit unless it is blanked.
//
//   Ports
//     i_clk        : clock, rising edge
//     i_rst_n      : synchronous active-low reset (priority over i_en)
//     i_en         : scan enable; low parks the scan in IDLE, all digits off
//     i_blank_mask : bit i = 1 keeps digit i dark for its slot
//     o_sel0       : mux select MSB (digit index bit 1)
//     o_sel1       : mux select LSB (digit index bit 0)
//     o_an         : active-low anode enables
//     o_scan_tick  : one-cycle pulse on each wrap from digit 3 to digit 0
//     o_dbg_state  : current FSM state (scan_state_e encoding)
//
//   All outputs are registered: each register is loaded with the value
//   decoded from the next state, so outputs change on the same edge as the
//   state they describe.
// ---------------------------------------------------------------------------
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 500
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [3:0] i_blank_mask,
  output logic       o_sel0,
  output logic       o_sel1,
  output logic [3:0] o_an,
  output logic       o_scan_tick,
  output logic [1:0] o_dbg_state
);

  localparam bit HAS_GUARD = (GUARD > 0);

  scan_state_e r_state;
  scan_state_e w_state_next;
  scan_state_e w_slot_entry;
  digit_idx_t  r_idx;
  digit_idx_t  w_idx_next;
  logic [3:0]  r_an;
  logic [3:0]  w_an_next;
  logic        r_tick;
  logic        w_tick_next;
  logic        w_guard_done;
  logic        w_slot_end;
  logic        w_timer_clear;

  // The counter only runs while scanning; IDLE and a dropped enable hold it
  // at 0 so the first scan cycle after a start is count 0.
  assign w_timer_clear = !i_en || (r_state == ST_IDLE);

  slot_timer #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) u_slot_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (w_timer_clear),
    .o_guard_done (w_guard_done),
    .o_slot_end   (w_slot_end)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_an    <= AN_OFF;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_an    <= w_an_next;
      r_tick  <= w_tick_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next state, next digit index and registered-output decode
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_tick_next  = 1'b0;
    w_an_next    = AN_OFF;

    // Every slot begins in GUARD, or straight in DRIVE when there is no guard.
    if (HAS_GUARD) begin
      w_slot_entry = ST_GUARD;
    end else begin
      w_slot_entry = ST_DRIVE;
    end

    // A dropped enable wins over any slot-end advance.
    if (!i_en) begin
      w_state_next = ST_IDLE;
      w_idx_next   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_idx_next   = '0;
          w_state_next = w_slot_entry;
        end
        ST_GUARD: begin
          if (w_guard_done) begin
            w_state_next = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (w_slot_end) begin
            w_idx_next   = r_idx + 2'd1;
            w_state_next = w_slot_entry;
            // Frame start: only a real 3->0 wrap, never the IDLE start.
            w_tick_next  = (r_idx == 2'd3);
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_idx_next   = '0;
        end
      endcase
    end

    if (w_state_next == ST_DRIVE) begin
      w_an_next = an_decode(w_idx_next, i_blank_mask);
    end
  end

  assign o_sel0      = r_idx[1];
  assign o_sel1      = r_idx[0];
  assign o_an        = r_an;
  assign o_scan_tick = r_tick;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
//   Two instances share the stimulus: dut_a (DIV=8, GUARD=2) and
//   dut_b (DIV=4, GUARD=0). The reference model tracks only the number of
//   cycles since the scan started and derives digit, slot position, anodes
//   and frame tick from it arithmetically.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic [3:0] mask;

  logic       a_sel0, a_sel1, a_tick;
  logic [3:0] a_an;
  logic [1:0] a_state;
  logic       b_sel0, b_sel1, b_tick;
  logic [3:0] b_an;
  logic [1:0] b_state;

  display_scan_ctrl #(.DIV(8), .GUARD(2)) dut_a (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_blank_mask (mask),
    .o_sel0       (a_sel0),
    .o_sel1       (a_sel1),
    .o_an         (a_an),
    .o_scan_tick  (a_tick),
    .o_dbg_state  (a_state)
  );

  display_scan_ctrl #(.DIV(4), .GUARD(0)) dut_b (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_blank_mask (mask),
    .o_sel0       (b_sel0),
    .o_sel1       (b_sel1),
    .o_an         (b_an),
    .o_scan_tick  (b_tick),
    .o_dbg_state  (b_state)
  );

  // ---------------- counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_t = cycles since the scan started (0 = first cycle after the start edge)
  bit         m_valid  = 1'b0;
  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [3:0] m_mask   = 4'h0;

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (!rst_n || !en) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t      = 0;
    end else begin
      m_t++;
    end
    m_mask = mask;
  end

  function automatic logic [1:0] exp_sel(input int div);
    if (!m_active) return 2'd0;
    return 2'((m_t / div) % 4);
  endfunction

  function automatic logic [3:0] exp_an(input int div, input int guard);
    logic [3:0] an;
    int d;
    an = 4'hF;
    if (!m_active) return an;
    if ((m_t % div) < guard) return an;
    d = (m_t / div) % 4;
    if (!m_mask[d]) an[d] = 1'b0;
    return an;
  endfunction

  function automatic logic exp_tick(input int div);
    return m_active && (m_t > 0) && ((m_t % (4 * div)) == 0);
  endfunction

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("a_sel",  {a_sel0, a_sel1}, exp_sel(8));
      chk("a_an",   a_an,             exp_an(8, 2));
      chk("a_tick", a_tick,           exp_tick(8));
      chk("b_sel",  {b_sel0, b_sel1}, exp_sel(4));
      chk("b_an",   b_an,             exp_an(4, 0));
      chk("b_tick", b_tick,           exp_tick(4));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the frame position lies in [lo,hi].
  task automatic wait_frame_pos(input string name, input int lo, input int hi);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (m_active && (m_t % 32) >= lo && (m_t % 32) <= hi) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, found, 1'b1);
  endtask

  logic [3:0] mask_tbl [4];

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    mask_tbl[0] = 4'b1010;
    mask_tbl[1] = 4'b1111;
    mask_tbl[2] = 4'b0011;
    mask_tbl[3] = 4'b0110;

    rst_n = 1'b0;
    en    = 1'b0;
    mask  = 4'h0;
    step(3);
    chk("rst_an",    a_an,             4'b1111);
    chk("rst_sel",   {a_sel0, a_sel1}, 2'b00);
    chk("rst_tick",  a_tick,           1'b0);
    chk("rst_state", a_state,          2'd0);

    rst_n = 1'b1;
    step(2);
    chk("idle_an", a_an, 4'b1111);

    en = 1'b1;
    step(1);                                  // t=0
    chk("start_a_an",   a_an,             4'b1111);
    chk("start_a_sel",  {a_sel0, a_sel1}, 2'b00);
    chk("start_a_tick", a_tick,           1'b0);
    chk("start_b_an",   b_an,             4'b1110);
    step(1);                                  // t=1
    chk("guard1_a_an",  a_an,             4'b1111);
    step(1);                                  // t=2
    chk("d0_a_an",      a_an,             4'b1110);
    step(6);                                  // t=8
    chk("d1_a_sel",     {a_sel0, a_sel1}, 2'b01);
    chk("d1_a_guard",   a_an,             4'b1111);
    chk("t8_b_an",      b_an,             4'b1011);
    chk("t8_b_sel",     {b_sel0, b_sel1}, 2'b10);
    step(2);                                  // t=10
    chk("d1_a_an",      a_an,             4'b1101);
    step(21);                                 // t=31
    chk("d3_a_an",      a_an,             4'b0111);
    chk("d3_a_sel",     {a_sel0, a_sel1}, 2'b11);
    chk("t31_a_tick",   a_tick,           1'b0);
    step(1);                                  // t=32
    chk("wrap_a_tick",  a_tick,           1'b1);
    chk("wrap_a_sel",   {a_sel0, a_sel1}, 2'b00);
    chk("wrap_a_an",    a_an,             4'b1111);
    chk("wrap_b_tick",  b_tick,           1'b1);
    step(1);                                  // t=33
    chk("post_a_tick",  a_tick,           1'b0);
    step(40);

    // Blank digits 0 and 2
    mask = 4'b0101;
    wait_frame_pos("find_d0_masked", 4, 6);
    chk("mask_d0_an", a_an, 4'b1111);
    wait_frame_pos("find_d1_masked", 12, 14);
    chk("mask_d1_an", a_an, 4'b1101);
    step(40);
    mask = 4'b0000;

    // Drop enable in the middle of digit 2's drive phase
    wait_frame_pos("find_d2_drive", 19, 21);
    en = 1'b0;
    step(1);
    chk("en_off_an",  a_an,             4'b1111);
    chk("en_off_sel", {a_sel0, a_sel1}, 2'b00);
    step(3);
    en = 1'b1;
    step(1);
    chk("reen_an",  a_an,             4'b1111);
    chk("reen_sel", {a_sel0, a_sel1}, 2'b00);
    step(2);
    chk("reen_d0_an", a_an, 4'b1110);

    // One-cycle reset during digit 3, enable held high
    wait_frame_pos("find_d3", 27, 29);
    rst_n = 1'b0;
    step(1);
    chk("midrst_an",    a_an,             4'b1111);
    chk("midrst_sel",   {a_sel0, a_sel1}, 2'b00);
    chk("midrst_state", a_state,          2'd0);
    rst_n = 1'b1;
    step(1);
    chk("resume_an",  a_an,             4'b1111);
    chk("resume_sel", {a_sel0, a_sel1}, 2'b00);
    step(2);
    chk("resume_d0_an", a_an, 4'b1110);

    // Mask changes at odd, mid-slot moments
    for (int i = 0; i < 4; i++) begin
      mask = mask_tbl[i];
      step(13 + i);
    end
    mask = 4'h0;
    step(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
